// File: rtl/mask_merge_pkg.sv
// Shared types and widths for the rotate-and-mask merge unit.
package mask_merge_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 6;
  localparam int HALF   = 32;

  typedef enum logic [1:0] {
    OP_ROTMASK = 2'b00,
    OP_INSERT  = 2'b01,
    OP_CLEAR   = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

endpackage

// File: rtl/range_mask_gen.sv
// Two-half range mask: bit i set iff low<=i<=high, Top selects for bits 63:32, Bot for 31:0.
module range_mask_gen
  import mask_merge_pkg::*;
(
  input  logic [SEL_W-1:0]  low_top,
  input  logic [SEL_W-1:0]  high_top,
  input  logic [SEL_W-1:0]  low_bot,
  input  logic [SEL_W-1:0]  high_bot,
  output logic [DATA_W-1:0] mask
);

  // Full 6-bit index compare; the out-of-half bound is trivially true by construction.
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    if (i >= HALF) begin : g_top
      assign mask[i] = (low_top <= IDX) && (high_top >= IDX);
    end else begin : g_bot
      assign mask[i] = (low_bot <= IDX) && (high_bot >= IDX);
    end
  end

endmodule

// File: rtl/mask_merge_unit.sv
// Rotate a source operand and merge it into a destination under a range mask.
// Two-stage valid/ready pipeline: stage 1 holds mask/rotated operands, stage 2 the result.
module mask_merge_unit
  import mask_merge_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src,
  input  logic [DATA_W-1:0] in_dst,
  input  logic [SEL_W-1:0]  in_rot,
  input  logic [SEL_W-1:0]  in_low_top,
  input  logic [SEL_W-1:0]  in_high_top,
  input  logic [SEL_W-1:0]  in_low_bot,
  input  logic [SEL_W-1:0]  in_high_bot,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  op_count
);

  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_mask_r;
  logic [DATA_W-1:0] s1_rot_r;
  logic [DATA_W-1:0] s1_dst_r;
  op_e               s1_op_r;
  logic [TAG_W-1:0]  s1_tag_r;

  logic [DATA_W-1:0] mask_s;
  logic [DATA_W-1:0] rot_s;
  logic [DATA_W-1:0] result_s;
  logic              illegal_s;
  logic              in_fire_s;
  logic              s1_adv_s;

  range_mask_gen u_mask (
    .low_top  (in_low_top),
    .high_top (in_high_top),
    .low_bot  (in_low_bot),
    .high_bot (in_high_bot),
    .mask     (mask_s)
  );

  // Left rotate; a shift of 64 on the right term yields zero, so rot=0 passes src through.
  assign rot_s = (in_src << in_rot) | (in_src >> (7'd64 - {1'b0, in_rot}));

  // Stage 1 may move on when stage 2 is empty or being drained this cycle.
  assign s1_adv_s  = s1_valid_r && (!out_valid || out_ready);
  assign in_ready  = !rst && (!s1_valid_r || !out_valid || out_ready);
  assign in_fire_s = in_valid && in_ready;

  // Merge of the stage-1 operands according to the opcode.
  always_comb begin
    result_s  = {DATA_W{1'b0}};
    illegal_s = 1'b0;
    case (s1_op_r)
      OP_ROTMASK: result_s = s1_rot_r & s1_mask_r;
      OP_INSERT:  result_s = (s1_rot_r & s1_mask_r) | (s1_dst_r & ~s1_mask_r);
      OP_CLEAR:   result_s = s1_dst_r & ~s1_mask_r;
      default: begin
        result_s  = {DATA_W{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  // Stage 1 operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_mask_r  <= {DATA_W{1'b0}};
      s1_rot_r   <= {DATA_W{1'b0}};
      s1_dst_r   <= {DATA_W{1'b0}};
      s1_op_r    <= OP_ROTMASK;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_r <= in_fire_s || (s1_valid_r && !s1_adv_s);
      if (in_fire_s) begin
        s1_mask_r <= mask_s;
        s1_rot_r  <= rot_s;
        s1_dst_r  <= in_dst;
        s1_op_r   <= op_e'(in_op);
        s1_tag_r  <= in_tag;
      end
    end
  end

  // Stage 2 output register; contents frozen while stalled by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= {DATA_W{1'b0}};
      out_tag     <= {TAG_W{1'b0}};
      out_illegal <= 1'b0;
    end else if (s1_adv_s) begin
      out_valid   <= 1'b1;
      out_result  <= result_s;
      out_tag     <= s1_tag_r;
      out_illegal <= illegal_s;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mask_merge_unit.sv
// Directed self-checking bench for mask_merge_unit.
module tb_mask_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_src;
  logic [63:0] in_dst;
  logic [5:0]  in_rot;
  logic [5:0]  in_low_top;
  logic [5:0]  in_high_top;
  logic [5:0]  in_low_bot;
  logic [5:0]  in_high_bot;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_tag;
  logic        out_illegal;
  logic [15:0] op_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mask_merge_unit #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src(in_src), .in_dst(in_dst), .in_rot(in_rot), .in_low_top(in_low_top),
    .in_high_top(in_high_top), .in_low_bot(in_low_bot), .in_high_bot(in_high_bot),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .op_count(op_count)
  );

  // Present one operation at a negedge (in_valid stays high until caller drops it).
  task automatic present(input logic [1:0] op, input logic [63:0] src, input logic [63:0] dst,
                         input logic [5:0] rot, input logic [5:0] lt, input logic [5:0] ht,
                         input logic [5:0] lb, input logic [5:0] hb, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_src = src; in_dst = dst; in_rot = rot;
    in_low_top = lt; in_high_top = ht; in_low_bot = lb; in_high_bot = hb; in_tag = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    present(2'b00, 64'h0, 64'h0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 4'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({out_valid, out_illegal, out_tag, out_result, op_count} !== 86'd0)
      $display("FAIL reset_outputs: got v=%b ill=%b tag=%h res=%h cnt=%0d required all zero",
               out_valid, out_illegal, out_tag, out_result, op_count);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
  endtask

  // Shared latency pattern for single ops: accepted at edge N, out_valid after edge N+1.
  task automatic test_rotmask;
    @(negedge clk);
    present(2'b00, 64'hFF, 64'h0, 6'd8, 6'd63, 6'd0, 6'd8, 6'd15, 4'd1);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rotmask_early: got out_valid=%b required 0", out_valid);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 64'h0000_0000_0000_FF00 || out_tag !== 4'd1)
      $display("FAIL rotmask: got v=%b res=%h tag=%h required v=1 res=000000000000ff00 tag=1",
               out_valid, out_result, out_tag);
    else pass_cnt++;
  endtask

  task automatic test_insert;
    present(2'b01, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 6'd63, 6'd0, 6'd4, 6'd7, 4'd2);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FF0F || out_illegal !== 1'b0)
      $display("FAIL insert: got v=%b res=%h ill=%b required v=1 res=ffffffffffffff0f ill=0",
               out_valid, out_result, out_illegal);
    else pass_cnt++;
  endtask

  task automatic test_full_mask_rotate;
    present(2'b00, 64'h8000_0000_0000_0001, 64'h0, 6'd1, 6'd32, 6'd63, 6'd0, 6'd31, 4'd3);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 64'h0000_0000_0000_0003)
      $display("FAIL rotate_wrap: got v=%b res=%h required v=1 res=0000000000000003",
               out_valid, out_result);
    else pass_cnt++;
  endtask

  task automatic test_clear;
    present(2'b10, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 6'd0, 6'd40, 6'd31, 6'd0, 4'd4);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FE00_FFFF_FFFF || out_tag !== 4'd4)
      $display("FAIL clear: got v=%b res=%h tag=%h required v=1 res=fffffe00ffffffff tag=4",
               out_valid, out_result, out_tag);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || op_count !== 16'd4)
      $display("FAIL drain_count: got v=%b cnt=%0d required v=0 cnt=4", out_valid, op_count);
    else pass_cnt++;
  endtask

  // Consumer stalled: two ops buffered, third refused, then released in order.
  task automatic test_back_to_back;
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    out_ready = 1'b0;
    present(2'b00, 64'h1111, 64'h0, 6'd0, 6'd32, 6'd63, 6'd0, 6'd31, 4'd1);
    @(posedge clk); @(negedge clk);
    present(2'b00, 64'h2222, 64'h0, 6'd0, 6'd32, 6'd63, 6'd0, 6'd31, 4'd2);
    @(posedge clk); @(negedge clk);
    present(2'b00, 64'h3333, 64'h0, 6'd0, 6'd32, 6'd63, 6'd0, 6'd31, 4'd3);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b required 0", in_ready);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_result !== 64'h1111 || in_ready !== 1'b0)
      $display("FAIL stall_hold: got v=%b tag=%h res=%h rdy=%b required v=1 tag=1 res=1111 rdy=0",
               out_valid, out_tag, out_result, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_result !== 64'h2222)
      $display("FAIL order_2: got v=%b tag=%h res=%h required v=1 tag=2 res=2222",
               out_valid, out_tag, out_result);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_result !== 64'h3333)
      $display("FAIL order_3: got v=%b tag=%h res=%h required v=1 tag=3 res=3333",
               out_valid, out_tag, out_result);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || op_count !== 16'd3)
      $display("FAIL stall_count: got v=%b cnt=%0d required v=0 cnt=3", out_valid, op_count);
    else pass_cnt++;
  endtask

  task automatic test_illegal_and_reset;
    present(2'b11, 64'hDEAD_BEEF, 64'hFFFF, 6'd3, 6'd32, 6'd63, 6'd0, 6'd31, 4'd9);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 64'h0 || out_illegal !== 1'b1 || out_tag !== 4'd9)
      $display("FAIL illegal: got v=%b res=%h ill=%b tag=%h required v=1 res=0 ill=1 tag=9",
               out_valid, out_result, out_illegal, out_tag);
    else pass_cnt++;
    out_ready = 1'b0;
    present(2'b00, 64'hABCD, 64'h0, 6'd0, 6'd32, 6'd63, 6'd0, 6'd31, 4'd5);
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || out_result !== 64'h0 || out_illegal !== 1'b0)
      $display("FAIL mid_reset: got v=%b cnt=%0d res=%h ill=%b required v=0 cnt=0 res=0 ill=0",
               out_valid, op_count, out_result, out_illegal);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || in_ready !== 1'b1)
      $display("FAIL stale_after_reset: got v=%b cnt=%0d rdy=%b required v=0 cnt=0 rdy=1",
               out_valid, op_count, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rotmask();
    test_insert();
    test_full_mask_rotate();
    test_clear();
    test_back_to_back();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
